mem_access_stage: RTL

//  MIPS MEM stage, directly downstream of execute. Registers ALU result, store data, branch target and controls.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/mem_access_stage_if.sv | 15 +
 rtl/dmem_req_fsm.sv | 81 ++++++++
 rtl/mem_access_stage.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS MEM stage: FSM states, pipeline bundles and address helpers.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [DATA_W-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } mem_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] write_reg;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
  } ex_mem_bundle_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } mem_wb_bundle_t;

  function automatic logic [DATA_W-1:0] word_addr(input logic [DATA_W-1:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Request/acknowledge data-memory port between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if;
  import mips_pkg::*;

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, output we, output addr, output wdata, input rdata, input ack);
  modport slave  (input req, input we, input addr, input wdata, output rdata, output ack);

endinterface

// File: rtl/dmem_req_fsm.sv
// Data-memory request sequencer: IDLE/ACCESS/DONE FSM, ack-wait counter and sticky error flag.
module dmem_req_fsm
  import mips_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       trap,
  input  logic       ack,
  output mem_state_t state,
  output logic       req,
  output logic       hold,
  output logic       done_ack,
  output logic       done_timeout,
  output logic       err
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  mem_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    req          = 1'b0;
    hold         = 1'b0;
    done_ack     = 1'b0;
    done_timeout = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        if (start) begin
          if (trap) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        req = 1'b1;
        if (ack) begin
          done_ack = 1'b1;
          state_d  = DONE;
        end else if (cnt_q == CntW'(MAX_WAIT - 1)) begin
          // This would be the MAX_WAIT-th unanswered cycle: give up.
          done_timeout = 1'b1;
          err_d        = 1'b1;
          state_d      = DONE;
        end else begin
          hold  = 1'b1;
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign state = state_q;
  assign err   = err_q;

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: registers the execute bundle, resolves branches, runs loads/stores, emits writeback.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of masking the low address bits.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic [DATA_W-1:0]   store_data,
  input  logic [DATA_W-1:0]   branch_target,
  input  logic                zero,
  input  logic                ctrl_branch,
  input  logic                ctrl_mem_read,
  input  logic                ctrl_mem_write,
  input  logic                ctrl_mem_to_reg,
  input  logic                ctrl_reg_write,
  input  logic [REG_AW-1:0]   write_reg,
  output logic                stall,
  output logic                pc_src,
  output logic [DATA_W-1:0]   pc_target,
  mem_access_stage_if.master  dmem,
  output logic                dmem_err,
  output logic                wb_valid,
  output logic                wb_reg_write,
  output logic [REG_AW-1:0]   wb_reg,
  output logic [DATA_W-1:0]   wb_data
);

  mem_state_t     state;
  logic           accept, mem_op, trap, taken;
  logic           fsm_req, fsm_hold, done_ack, done_timeout;
  ex_mem_bundle_t ex_d, ex_q;
  mem_wb_bundle_t wb_d, wb_q;
  logic           pc_src_q;
  logic [DATA_W-1:0] pc_target_q;

  // ACCESS owns the stage; the bundle upstream re-presents meanwhile is the one already captured.
  assign accept = in_valid && (state != ACCESS);
  assign mem_op = (ctrl_mem_read || ctrl_mem_write) && !ctrl_branch;
  assign taken  = accept && ctrl_branch && zero;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = mem_op && (alu_result[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  dmem_req_fsm #(
    .MAX_WAIT(MAX_WAIT)
  ) u_dmem_req_fsm (
    .clk         (clk),
    .reset       (reset),
    .start       (accept && mem_op),
    .trap        (trap),
    .ack         (dmem.ack),
    .state       (state),
    .req         (fsm_req),
    .hold        (fsm_hold),
    .done_ack    (done_ack),
    .done_timeout(done_timeout),
    .err         (dmem_err)
  );

  assign stall = (accept && mem_op) || fsm_hold;

  always_comb begin
    ex_d            = ex_q;
    ex_d.alu_result = alu_result;
    ex_d.store_data = store_data;
    ex_d.write_reg  = write_reg;
    ex_d.mem_read   = ctrl_mem_read && !ctrl_branch;
    ex_d.mem_write  = ctrl_mem_write && !ctrl_branch;
    ex_d.mem_to_reg = ctrl_mem_to_reg;
    ex_d.reg_write  = ctrl_reg_write && !ctrl_branch;
  end

  always_comb begin
    wb_d = '0;
    if (done_ack || done_timeout) begin
      wb_d.valid     = 1'b1;
      wb_d.rd        = ex_q.write_reg;
      wb_d.reg_write = done_ack && ex_q.mem_read && ex_q.reg_write;
      wb_d.data      = (done_ack && ex_q.mem_to_reg) ? dmem.rdata : ex_q.alu_result;
    end else if (accept && (!mem_op || trap)) begin
      wb_d.valid     = 1'b1;
      wb_d.rd        = write_reg;
      wb_d.reg_write = ctrl_reg_write && !ctrl_branch && !trap;
      wb_d.data      = alu_result;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q        <= '0;
      wb_q        <= '0;
      pc_src_q    <= 1'b0;
      pc_target_q <= '0;
    end else begin
      if (accept) begin
        ex_q <= ex_d;
      end
      wb_q     <= wb_d;
      pc_src_q <= taken;
      if (taken) begin
        pc_target_q <= branch_target;
      end
    end
  end

  assign dmem.req   = fsm_req;
  assign dmem.we    = fsm_req && ex_q.mem_write;
  assign dmem.addr  = fsm_req ? word_addr(ex_q.alu_result) : '0;
  assign dmem.wdata = fsm_req ? ex_q.store_data : '0;

  assign pc_src       = pc_src_q;
  assign pc_target    = pc_target_q;
  assign wb_valid     = wb_q.valid;
  assign wb_reg_write = wb_q.reg_write;
  assign wb_reg       = wb_q.rd;
  assign wb_data      = wb_q.data;

endmodule
